expr_checker: RTL and testbench

- Streaming arithmetic-expression validator; consumes one ASCII character per accepted cycle and reports, after every character, whether the prefix so far is a complete well-formed expression.
- Generalises the single-level checker: configurable nesting depth, optional multi-digit operands, optional '-' operator, whitespace skipping, an input-valid qualifier, and diagnostic outputs (depth, first-error position).
- Sits between a character source (UART/testbench stream) and a control block.

---
 rtl/expr_pkg.sv | 33 +++
 rtl/expr_char_class.sv | 27 ++
 rtl/expr_checker.sv | 116 +++++++++++
 tb/tb_expr_checker.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/expr_pkg.sv
// Shared types and character constants for the expression parser blocks.
package expr_pkg;

    // Parser FSM states.
    typedef enum logic [2:0] {
        ST_START = 3'd0,
        ST_LPAR  = 3'd1,
        ST_NUM   = 3'd2,
        ST_OPR   = 3'd3,
        ST_RPAR  = 3'd4,
        ST_ERR   = 3'd5
    } state_t;

    // Character classes produced by expr_char_class.
    typedef enum logic [2:0] {
        CC_DIGIT = 3'd0,
        CC_OP    = 3'd1,
        CC_LP    = 3'd2,
        CC_RP    = 3'd3,
        CC_SP    = 3'd4,
        CC_OTHER = 3'd5
    } char_class_t;

    localparam logic [7:0] ASCII_LP    = 8'h28; // '('
    localparam logic [7:0] ASCII_RP    = 8'h29; // ')'
    localparam logic [7:0] ASCII_PLUS  = 8'h2B; // '+'
    localparam logic [7:0] ASCII_STAR  = 8'h2A; // '*'
    localparam logic [7:0] ASCII_MINUS = 8'h2D; // '-'
    localparam logic [7:0] ASCII_0     = 8'h30; // '0'
    localparam logic [7:0] ASCII_9     = 8'h39; // '9'
    localparam logic [7:0] ASCII_SP    = 8'h20; // ' '

endpackage

// File: rtl/expr_char_class.sv
// Combinational ASCII character classifier for the expression parsers.
module expr_char_class
    import expr_pkg::*;
(
    input  logic [7:0]  char_i,
    input  logic        allow_minus_i,
    output char_class_t cls_o
);

    // Map one character to its class; '-' is an operator only when enabled.
    always_comb begin
        cls_o = CC_OTHER;
        if (char_i >= ASCII_0 && char_i <= ASCII_9) begin
            cls_o = CC_DIGIT;
        end else if (char_i == ASCII_PLUS || char_i == ASCII_STAR ||
                     (allow_minus_i && char_i == ASCII_MINUS)) begin
            cls_o = CC_OP;
        end else if (char_i == ASCII_LP) begin
            cls_o = CC_LP;
        end else if (char_i == ASCII_RP) begin
            cls_o = CC_RP;
        end else if (char_i == ASCII_SP) begin
            cls_o = CC_SP;
        end
    end

endmodule

// File: rtl/expr_checker.sv
// Streaming arithmetic-expression validator: one character per in_valid
// cycle, reports whether the prefix consumed so far is a complete expression.
module expr_checker
    import expr_pkg::*;
#(
    parameter int MAX_DEPTH   = 7,
    parameter int DEPTH_W     = 3,
    parameter int POS_W       = 8,
    parameter int MULTI_DIGIT = 1,
    parameter int ALLOW_MINUS = 0
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               in_valid,
    input  logic [7:0]         in,
    output logic               out,
    output logic               err,
    output logic [DEPTH_W-1:0] depth,
    output logic [POS_W-1:0]   err_pos,
    output logic [POS_W-1:0]   pos
);

    state_t             state_q, state_d;
    logic [DEPTH_W-1:0] depth_q, depth_d;
    logic               err_q, err_d;
    logic [POS_W-1:0]   err_pos_q, err_pos_d;
    logic [POS_W-1:0]   pos_q, pos_d;
    char_class_t        cls;
    logic               go_err;
    logic               at_max;
    logic               at_zero;

    expr_char_class u_class (
        .char_i        (in),
        .allow_minus_i (ALLOW_MINUS != 0),
        .cls_o         (cls)
    );

    assign at_max  = (depth_q == DEPTH_W'(MAX_DEPTH));
    assign at_zero = (depth_q == '0);

    // Next-state: grammar transitions, depth bounds, saturating position.
    // Spaces only advance pos; ERR absorbs everything else until clr.
    always_comb begin
        state_d   = state_q;
        depth_d   = depth_q;
        err_d     = err_q;
        err_pos_d = err_pos_q;
        pos_d     = pos_q;
        go_err    = 1'b0;
        if (in_valid) begin
            if (pos_q != '1) begin
                pos_d = pos_q + 1'b1;
            end
            if (cls != CC_SP && state_q != ST_ERR) begin
                case (state_q)
                    ST_START, ST_OPR, ST_LPAR: begin
                        if (cls == CC_DIGIT) begin
                            state_d = ST_NUM;
                        end else if (cls == CC_LP && !at_max) begin
                            state_d = ST_LPAR;
                            depth_d = depth_q + 1'b1;
                        end else begin
                            go_err = 1'b1;
                        end
                    end
                    ST_NUM, ST_RPAR: begin
                        if (cls == CC_OP) begin
                            state_d = ST_OPR;
                        end else if (cls == CC_RP && !at_zero) begin
                            state_d = ST_RPAR;
                            depth_d = depth_q - 1'b1;
                        end else if (state_q == ST_NUM && cls == CC_DIGIT &&
                                     MULTI_DIGIT != 0) begin
                            state_d = ST_NUM;
                        end else begin
                            go_err = 1'b1;
                        end
                    end
                    default: go_err = 1'b1;
                endcase
                if (go_err) begin
                    state_d   = ST_ERR;
                    depth_d   = depth_q;
                    err_d     = 1'b1;
                    err_pos_d = pos_q;
                end
            end
        end
    end

    // State registers with asynchronous active-high clear.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= ST_START;
            depth_q   <= '0;
            err_q     <= 1'b0;
            err_pos_q <= '0;
            pos_q     <= '0;
        end else begin
            state_q   <= state_d;
            depth_q   <= depth_d;
            err_q     <= err_d;
            err_pos_q <= err_pos_d;
            pos_q     <= pos_d;
        end
    end

    // Outputs come straight from registers (one-cycle latency from in).
    assign out     = (state_q == ST_NUM || state_q == ST_RPAR) && at_zero && !err_q;
    assign err     = err_q;
    assign depth   = depth_q;
    assign err_pos = err_pos_q;
    assign pos     = pos_q;

endmodule

// File: tb/tb_expr_checker.sv
// Directed testbench for expr_checker: three instances (defaults,
// single-digit operands, minus enabled) share one character stream.
module tb_expr_checker;

    logic       clk;
    logic       clr;
    logic       in_valid;
    logic [7:0] in;

    logic       d_out, d_err;
    logic [2:0] d_depth;
    logic [7:0] d_err_pos, d_pos;
    logic       s_out, s_err;
    logic [2:0] s_depth;
    logic [7:0] s_err_pos, s_pos;
    logic       m_out, m_err;
    logic [2:0] m_depth;
    logic [7:0] m_err_pos, m_pos;

    int n_checks = 0;
    int n_errors = 0;

    expr_checker u_def (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
        .out(d_out), .err(d_err), .depth(d_depth), .err_pos(d_err_pos), .pos(d_pos)
    );

    expr_checker #(.MULTI_DIGIT(0)) u_sd (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
        .out(s_out), .err(s_err), .depth(s_depth), .err_pos(s_err_pos), .pos(s_pos)
    );

    expr_checker #(.ALLOW_MINUS(1)) u_am (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
        .out(m_out), .err(m_err), .depth(m_depth), .err_pos(m_err_pos), .pos(m_pos)
    );

    // Clock: 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one character, sample 1 ns after the consuming edge.
    task automatic send(input logic [7:0] c);
        @(negedge clk);
        in_valid = 1'b1;
        in       = c;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in       = 8'h00;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    task automatic bubble();
        @(negedge clk);
        in_valid = 1'b0;
        in       = 8'h41;
        @(posedge clk);
        #1;
        in = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        clr = 1'b1;
        in_valid = 1'b0;
        in = 8'h00;
        #12;
        n_checks += 5;
        if (d_out !== 1'b0) begin n_errors++; $display("FAIL reset_out got=%b exp=0", d_out); end
        if (d_err !== 1'b0) begin n_errors++; $display("FAIL reset_err got=%b exp=0", d_err); end
        if (d_depth !== 3'd0) begin n_errors++; $display("FAIL reset_depth got=%0d exp=0", d_depth); end
        if (d_pos !== 8'd0) begin n_errors++; $display("FAIL reset_pos got=%0d exp=0", d_pos); end
        if (d_err_pos !== 8'd0) begin n_errors++; $display("FAIL reset_err_pos got=%0d exp=0", d_err_pos); end
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_basic();
        string s   = "(1+23)*4";
        string exp = "00000101";
        do_reset();
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            n_checks++;
            if (d_out !== (exp[i] == "1")) begin
                n_errors++;
                $display("FAIL basic_out idx=%0d got=%b exp=%s", i, d_out, exp[i]);
            end
        end
        n_checks += 3;
        if (d_err !== 1'b0) begin n_errors++; $display("FAIL basic_err got=%b exp=0", d_err); end
        if (d_depth !== 3'd0) begin n_errors++; $display("FAIL basic_depth got=%0d exp=0", d_depth); end
        if (d_pos !== 8'd8) begin n_errors++; $display("FAIL basic_pos got=%0d exp=8", d_pos); end
    endtask

    task automatic test_multi_digit();
        do_reset();
        send_str("12");
        n_checks += 4;
        if (s_err !== 1'b1) begin n_errors++; $display("FAIL sd_err got=%b exp=1", s_err); end
        if (s_err_pos !== 8'd1) begin n_errors++; $display("FAIL sd_err_pos got=%0d exp=1", s_err_pos); end
        if (s_out !== 1'b0) begin n_errors++; $display("FAIL sd_out got=%b exp=0", s_out); end
        if (d_out !== 1'b1) begin n_errors++; $display("FAIL md_out got=%b exp=1", d_out); end
        send_str("((");
        n_checks += 4;
        if (s_err !== 1'b1) begin n_errors++; $display("FAIL sd_sticky_err got=%b exp=1", s_err); end
        if (s_depth !== 3'd0) begin n_errors++; $display("FAIL sd_frozen_depth got=%0d exp=0", s_depth); end
        if (s_err_pos !== 8'd1) begin n_errors++; $display("FAIL sd_held_err_pos got=%0d exp=1", s_err_pos); end
        if (s_pos !== 8'd4) begin n_errors++; $display("FAIL sd_pos got=%0d exp=4", s_pos); end
    endtask

    task automatic test_depth();
        do_reset();
        for (int i = 0; i < 7; i++) send("(");
        n_checks += 2;
        if (d_depth !== 3'd7) begin n_errors++; $display("FAIL depth_max got=%0d exp=7", d_depth); end
        if (d_err !== 1'b0) begin n_errors++; $display("FAIL depth_max_err got=%b exp=0", d_err); end
        send("(");
        n_checks += 3;
        if (d_err !== 1'b1) begin n_errors++; $display("FAIL depth_over_err got=%b exp=1", d_err); end
        if (d_err_pos !== 8'd7) begin n_errors++; $display("FAIL depth_over_pos got=%0d exp=7", d_err_pos); end
        if (d_depth !== 3'd7) begin n_errors++; $display("FAIL depth_over_depth got=%0d exp=7", d_depth); end
        send(")");
        n_checks++;
        if (d_depth !== 3'd7) begin n_errors++; $display("FAIL depth_frozen got=%0d exp=7", d_depth); end
    endtask

    task automatic test_underflow_minus();
        do_reset();
        send_str("1)");
        n_checks += 3;
        if (d_err !== 1'b1) begin n_errors++; $display("FAIL under_err got=%b exp=1", d_err); end
        if (d_err_pos !== 8'd1) begin n_errors++; $display("FAIL under_err_pos got=%0d exp=1", d_err_pos); end
        if (d_depth !== 3'd0) begin n_errors++; $display("FAIL under_depth got=%0d exp=0", d_depth); end
        do_reset();
        send_str("3-4");
        n_checks += 5;
        if (d_err_pos !== 8'd1) begin n_errors++; $display("FAIL minus_off_err_pos got=%0d exp=1", d_err_pos); end
        if (d_err !== 1'b1) begin n_errors++; $display("FAIL minus_off_err got=%b exp=1", d_err); end
        if (d_out !== 1'b0) begin n_errors++; $display("FAIL minus_off_out got=%b exp=0", d_out); end
        if (m_out !== 1'b1) begin n_errors++; $display("FAIL minus_on_out got=%b exp=1", m_out); end
        if (m_err !== 1'b0) begin n_errors++; $display("FAIL minus_on_err got=%b exp=0", m_err); end
    endtask

    task automatic test_spaces_bubbles();
        string s = "( 5 )";
        do_reset();
        for (int i = 0; i < s.len(); i++) begin
            send(s[i]);
            bubble();
            bubble();
            n_checks++;
            if (d_pos !== 8'(i + 1)) begin
                n_errors++;
                $display("FAIL bubble_pos idx=%0d got=%0d exp=%0d", i, d_pos, i + 1);
            end
        end
        n_checks += 4;
        if (d_out !== 1'b1) begin n_errors++; $display("FAIL space_out got=%b exp=1", d_out); end
        if (d_pos !== 8'd5) begin n_errors++; $display("FAIL space_pos got=%0d exp=5", d_pos); end
        if (d_err !== 1'b0) begin n_errors++; $display("FAIL space_err got=%b exp=0", d_err); end
        if (d_depth !== 3'd0) begin n_errors++; $display("FAIL space_depth got=%0d exp=0", d_depth); end
    endtask

    task automatic test_async_clr();
        do_reset();
        send_str("((7");
        n_checks += 2;
        if (d_depth !== 3'd2) begin n_errors++; $display("FAIL pre_clr_depth got=%0d exp=2", d_depth); end
        if (d_pos !== 8'd3) begin n_errors++; $display("FAIL pre_clr_pos got=%0d exp=3", d_pos); end
        #1;
        clr = 1'b1;
        #1;
        n_checks += 3;
        if (d_depth !== 3'd0) begin n_errors++; $display("FAIL async_clr_depth got=%0d exp=0", d_depth); end
        if (d_pos !== 8'd0) begin n_errors++; $display("FAIL async_clr_pos got=%0d exp=0", d_pos); end
        if (d_out !== 1'b0) begin n_errors++; $display("FAIL async_clr_out got=%b exp=0", d_out); end
        #1;
        clr = 1'b0;
        send("9");
        n_checks += 2;
        if (d_out !== 1'b1) begin n_errors++; $display("FAIL post_clr_out got=%b exp=1", d_out); end
        if (d_pos !== 8'd1) begin n_errors++; $display("FAIL post_clr_pos got=%0d exp=1", d_pos); end
    endtask

    task automatic test_pos_saturation();
        do_reset();
        for (int i = 0; i < 260; i++) send(" ");
        n_checks += 2;
        if (d_pos !== 8'd255) begin n_errors++; $display("FAIL sat_pos got=%0d exp=255", d_pos); end
        if (d_err !== 1'b0) begin n_errors++; $display("FAIL sat_err got=%b exp=0", d_err); end
        send("x");
        n_checks += 3;
        if (d_err !== 1'b1) begin n_errors++; $display("FAIL sat_other_err got=%b exp=1", d_err); end
        if (d_err_pos !== 8'd255) begin n_errors++; $display("FAIL sat_err_pos got=%0d exp=255", d_err_pos); end
        if (d_pos !== 8'd255) begin n_errors++; $display("FAIL sat_pos_hold got=%0d exp=255", d_pos); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multi_digit();
        test_depth();
        test_underflow_minus();
        test_spaces_bubbles();
        test_async_clr();
        test_pos_saturation();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
